// File: rtl/sm83_irq_ctrl_if.sv
// Purpose : bundles the peripheral, register-bus and core-dispatch signals of sm83_irq_ctrl.
// Ports   : IRQ_TRIG/IRQ_ACK (peripherals), REG_WR/REG_SEL/DIN/DOUT (register bus),
//           IME_SET/IME_CLR/INT_REQ/INT_TAKE/VECTOR/WAKE (core side).
// master = the core/peripheral side driving requests; slave = the controller.
interface sm83_irq_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] IRQ_TRIG;
  logic [NUM_IRQ-1:0] IRQ_ACK;
  logic               REG_WR;
  logic               REG_SEL;
  logic [NUM_IRQ-1:0] DIN;
  logic [NUM_IRQ-1:0] DOUT;
  logic               IME_SET;
  logic               IME_CLR;
  logic               INT_REQ;
  logic               INT_TAKE;
  logic [15:0]        VECTOR;
  logic               WAKE;

  modport master (
    output IRQ_TRIG, REG_WR, REG_SEL, DIN, IME_SET, IME_CLR, INT_TAKE,
    input  IRQ_ACK, DOUT, INT_REQ, VECTOR, WAKE
  );

  modport slave (
    input  IRQ_TRIG, REG_WR, REG_SEL, DIN, IME_SET, IME_CLR, INT_TAKE,
    output IRQ_ACK, DOUT, INT_REQ, VECTOR, WAKE
  );
endinterface

// File: rtl/sm83_irq_ctrl.sv
// Purpose : SM83-style interrupt controller: IF/IE/IME registers, fixed lowest-index priority, dispatch FSM.
// Latency : trigger edge in cycle n -> IF in n+1 -> INT_REQ in n+2; INT_TAKE in REQ -> IRQ_ACK/VECTOR next cycle.
// Backpr. : INT_REQ is held until the core answers with INT_TAKE or the request evaporates; no queueing.
// Ports   : CLK, nRESET (async active-low); bus (slave modport) carries triggers, acks,
//           register bus (REG_WR/REG_SEL/DIN/DOUT), IME control, INT_REQ/INT_TAKE, VECTOR, WAKE.
module sm83_irq_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] LEVEL_MASK = 16'h0000,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8
) (
  input logic            CLK,
  input logic            nRESET,
  sm83_irq_ctrl_if.slave bus
);

  localparam logic [NUM_IRQ-1:0] LVL      = LEVEL_MASK[NUM_IRQ-1:0];
  localparam logic [15:0]        STRIDE16 = 16'(VEC_STRIDE);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DISPATCH} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [NUM_IRQ-1:0] ie_q, ie_d;
  logic [NUM_IRQ-1:0] trig_q, trig_d;
  logic [NUM_IRQ-1:0] sel_q, sel_d;
  logic [NUM_IRQ-1:0] dout_q, dout_d;
  logic               ime_q, ime_d;
  logic [15:0]        vec_q, vec_d;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] hw_set;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [3:0]         win_idx;
  logic               any_pending;
  logic               dispatching;
  logic               int_req;
  logic [NUM_IRQ-1:0] irq_ack;

  assign pending     = if_q & ie_q;
  assign any_pending = |pending;

  // Level channels set IF every cycle the input is high; edge channels only on a 0->1 versus last cycle.
  assign hw_set = (bus.IRQ_TRIG & LVL) | (bus.IRQ_TRIG & ~trig_q & ~LVL);

  // Walk downwards so the lowest pending index is the one left standing.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx       = 4'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // A dispatch needs the request to still be valid in the same cycle as INT_TAKE.
  assign dispatching = (state_q == ST_REQ) && ime_q && any_pending && bus.INT_TAKE;

  // FSM: state register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:     state_d = (ime_q && any_pending) ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (!(ime_q && any_pending)) state_d = ST_IDLE;
        else if (bus.INT_TAKE)       state_d = ST_DISPATCH;
        else                         state_d = ST_REQ;
      end
      ST_DISPATCH: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs (Moore; ACK comes from the latched winner, so reset kills it at once)
  always_comb begin
    int_req = 1'b0;
    irq_ack = '0;
    case (state_q)
      ST_REQ:      int_req = 1'b1;
      ST_DISPATCH: irq_ack = sel_q;
      default:     ;
    endcase
  end

  // Register datapath. IF order matters: software write, then dispatch clear, then hardware set wins.
  always_comb begin
    trig_d = bus.IRQ_TRIG;
    if_d   = (bus.REG_WR && !bus.REG_SEL) ? bus.DIN : if_q;
    if (dispatching) if_d = if_d & ~win_onehot;
    if_d   = if_d | hw_set;
    ie_d   = (bus.REG_WR && bus.REG_SEL) ? bus.DIN : ie_q;
    if (bus.IME_CLR || dispatching) ime_d = 1'b0;
    else if (bus.IME_SET)           ime_d = 1'b1;
    else                            ime_d = ime_q;
    sel_d  = dispatching ? win_onehot : sel_q;
    vec_d  = dispatching ? (VEC_BASE + STRIDE16 * 16'(win_idx)) : vec_q;
    dout_d = bus.REG_SEL ? ie_d : if_d;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      if_q   <= '0;
      ie_q   <= '0;
      trig_q <= '0;
      sel_q  <= '0;
      dout_q <= '0;
      ime_q  <= 1'b0;
      vec_q  <= VEC_BASE;
    end else begin
      if_q   <= if_d;
      ie_q   <= ie_d;
      trig_q <= trig_d;
      sel_q  <= sel_d;
      dout_q <= dout_d;
      ime_q  <= ime_d;
      vec_q  <= vec_d;
    end
  end

  assign bus.INT_REQ = int_req;
  assign bus.IRQ_ACK = irq_ack;
  assign bus.VECTOR  = vec_q;
  assign bus.DOUT    = dout_q;
  assign bus.WAKE    = any_pending;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
module tb_sm83_irq_ctrl;

  localparam int         N   = 8;
  localparam logic [7:0] LVL = 8'h01;

  logic CLK;
  logic nRESET;
  int   checks = 0;
  int   errors = 0;

  sm83_irq_ctrl_if #(.NUM_IRQ(N)) bus ();

  sm83_irq_ctrl #(
    .NUM_IRQ(N), .LEVEL_MASK(16'h0001), .VEC_BASE(16'h0040), .VEC_STRIDE(8)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // phase: 0 = nothing asked, 1 = asking the core, 2 = acknowledging
  logic [7:0]  m_if, m_ie, m_prev, m_ack, m_dout;
  logic        m_ime;
  int          m_phase;
  logic [15:0] m_vec;

  task automatic model_reset();
    m_if = 0; m_ie = 0; m_prev = 0; m_ack = 0; m_dout = 0;
    m_ime = 0; m_phase = 0; m_vec = 16'h0040;
  endtask

  task automatic model_clock();
    logic [7:0] pend, nset, nif, nie, wbit;
    logic       nime, took;
    int         win, nphase;
    pend = m_if & m_ie;
    win  = -1;
    for (int i = 0; i < N; i++) if (pend[i] && win < 0) win = i;
    for (int i = 0; i < N; i++)
      nset[i] = LVL[i] ? bus.IRQ_TRIG[i] : (bus.IRQ_TRIG[i] && !m_prev[i]);
    took = (m_phase == 1) && m_ime && (win >= 0) && bus.INT_TAKE;
    wbit = took ? (8'b1 << win) : 8'b0;
    nif  = ((bus.REG_WR && !bus.REG_SEL) ? bus.DIN : m_if) & ~wbit | nset;
    nie  = (bus.REG_WR && bus.REG_SEL) ? bus.DIN : m_ie;
    nime = (bus.IME_CLR || took) ? 1'b0 : (bus.IME_SET ? 1'b1 : m_ime);
    if (m_phase == 0)      nphase = (m_ime && win >= 0) ? 1 : 0;
    else if (m_phase == 1) nphase = !(m_ime && win >= 0) ? 0 : (bus.INT_TAKE ? 2 : 1);
    else                   nphase = 0;
    if (took) begin
      m_vec = 16'h0040 + 16'(8 * win);
      m_ack = wbit;
    end
    m_prev  = bus.IRQ_TRIG;
    m_if    = nif;
    m_ie    = nie;
    m_ime   = nime;
    m_phase = nphase;
    m_dout  = bus.REG_SEL ? nie : nif;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.IRQ_TRIG = 0; bus.REG_WR = 0; bus.REG_SEL = 0; bus.DIN = 0;
    bus.IME_SET = 0; bus.IME_CLR = 0; bus.INT_TAKE = 0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (nRESET) model_clock();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRESET = 1'b0;
    model_reset();
    cycle();
    cycle();
    nRESET = 1'b1;
  endtask

  task automatic write_reg(input logic sel, input logic [7:0] val);
    bus.REG_WR = 1; bus.REG_SEL = sel; bus.DIN = val;
    cycle();
    bus.REG_WR = 0; bus.REG_SEL = 0; bus.DIN = 0;
  endtask

  task automatic pulse_ime_set();
    bus.IME_SET = 1;
    cycle();
    bus.IME_SET = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    nRESET = 1'b1;
    #1 nRESET = 1'b0;
    #1;
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b want 0", bus.INT_REQ); end
    checks++; if (bus.IRQ_ACK !== 8'h00) begin errors++; $display("FAIL reset_ack: got %h want 00", bus.IRQ_ACK); end
    checks++; if (bus.VECTOR !== 16'h0040) begin errors++; $display("FAIL reset_vector: got %h want 0040", bus.VECTOR); end
    checks++; if (bus.DOUT !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.DOUT); end
    checks++; if (bus.WAKE !== 1'b0) begin errors++; $display("FAIL reset_wake: got %b want 0", bus.WAKE); end
    do_reset();
  endtask

  task automatic test_basic_dispatch();
    do_reset();
    write_reg(1'b1, 8'h05);
    checks++; if (bus.DOUT !== 8'h05) begin errors++; $display("FAIL basic_ie_read: got %h want 05", bus.DOUT); end
    pulse_ime_set();
    bus.IRQ_TRIG = 8'h04;
    cycle();
    bus.IRQ_TRIG = 8'h00;
    checks++; if (bus.DOUT !== 8'h04) begin errors++; $display("FAIL basic_if_set: got %h want 04", bus.DOUT); end
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b want 0", bus.INT_REQ); end
    checks++; if (bus.WAKE !== 1'b1) begin errors++; $display("FAIL basic_wake: got %b want 1", bus.WAKE); end
    cycle();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", bus.INT_REQ); end
    bus.INT_TAKE = 1;
    cycle();
    bus.INT_TAKE = 0;
    checks++; if (bus.IRQ_ACK !== 8'h04) begin errors++; $display("FAIL basic_ack: got %h want 04", bus.IRQ_ACK); end
    checks++; if (bus.VECTOR !== 16'h0050) begin errors++; $display("FAIL basic_vector: got %h want 0050", bus.VECTOR); end
    checks++; if (bus.DOUT !== 8'h00) begin errors++; $display("FAIL basic_if_clr: got %h want 00", bus.DOUT); end
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b want 0", bus.INT_REQ); end
    cycle();
    checks++; if (bus.IRQ_ACK !== 8'h00) begin errors++; $display("FAIL basic_ack_one_cycle: got %h want 00", bus.IRQ_ACK); end
    checks++; if (bus.VECTOR !== 16'h0050) begin errors++; $display("FAIL basic_vector_hold: got %h want 0050", bus.VECTOR); end
    // IME was cleared by the dispatch: a new request must only wake, not interrupt
    bus.IRQ_TRIG = 8'h04;
    cycle();
    bus.IRQ_TRIG = 8'h00;
    cycle();
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL basic_ime_cleared: got %b want 0", bus.INT_REQ); end
    checks++; if (bus.WAKE !== 1'b1) begin errors++; $display("FAIL basic_wake_again: got %b want 1", bus.WAKE); end
  endtask

  task automatic test_priority();
    do_reset();
    write_reg(1'b1, 8'hFF);
    write_reg(1'b0, 8'h0A);
    checks++; if (bus.DOUT !== 8'h0A) begin errors++; $display("FAIL prio_if: got %h want 0a", bus.DOUT); end
    pulse_ime_set();
    cycle();
    bus.INT_TAKE = 1;
    cycle();
    bus.INT_TAKE = 0;
    checks++; if (bus.IRQ_ACK !== 8'h02) begin errors++; $display("FAIL prio_ack1: got %h want 02", bus.IRQ_ACK); end
    checks++; if (bus.VECTOR !== 16'h0048) begin errors++; $display("FAIL prio_vec1: got %h want 0048", bus.VECTOR); end
    checks++; if (bus.DOUT !== 8'h08) begin errors++; $display("FAIL prio_if1: got %h want 08", bus.DOUT); end
    pulse_ime_set();
    cycle();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL prio_req2: got %b want 1", bus.INT_REQ); end
    bus.INT_TAKE = 1;
    cycle();
    bus.INT_TAKE = 0;
    checks++; if (bus.IRQ_ACK !== 8'h08) begin errors++; $display("FAIL prio_ack2: got %h want 08", bus.IRQ_ACK); end
    checks++; if (bus.VECTOR !== 16'h0058) begin errors++; $display("FAIL prio_vec2: got %h want 0058", bus.VECTOR); end
    checks++; if (bus.DOUT !== 8'h00) begin errors++; $display("FAIL prio_if2: got %h want 00", bus.DOUT); end
  endtask

  task automatic test_cancel();
    do_reset();
    write_reg(1'b1, 8'h04);
    pulse_ime_set();
    write_reg(1'b0, 8'h04);
    cycle();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL cancel_req: got %b want 1", bus.INT_REQ); end
    write_reg(1'b1, 8'h00);
    bus.INT_TAKE = 1;
    cycle();
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL cancel_req_drop: got %b want 0", bus.INT_REQ); end
    checks++; if (bus.IRQ_ACK !== 8'h00) begin errors++; $display("FAIL cancel_no_ack: got %h want 00", bus.IRQ_ACK); end
    checks++; if (bus.WAKE !== 1'b0) begin errors++; $display("FAIL cancel_wake: got %b want 0", bus.WAKE); end
    checks++; if (bus.DOUT !== 8'h04) begin errors++; $display("FAIL cancel_if_kept: got %h want 04", bus.DOUT); end
    bus.INT_TAKE = 0;
    cycle();
    checks++; if (bus.IRQ_ACK !== 8'h00) begin errors++; $display("FAIL cancel_no_ack_late: got %h want 00", bus.IRQ_ACK); end
  endtask

  task automatic test_wake_and_write_race();
    do_reset();
    write_reg(1'b1, 8'h01);
    bus.IRQ_TRIG = 8'h01;
    cycle();
    bus.IRQ_TRIG = 8'h00;
    checks++; if (bus.WAKE !== 1'b1) begin errors++; $display("FAIL wake_set: got %b want 1", bus.WAKE); end
    cycle();
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL wake_no_req: got %b want 0", bus.INT_REQ); end
    write_reg(1'b0, 8'h00);
    checks++; if (bus.WAKE !== 1'b0) begin errors++; $display("FAIL wake_cleared: got %b want 0", bus.WAKE); end
    // software clears IF in the very cycle new triggers arrive: hardware must win
    bus.IRQ_TRIG = 8'h05;
    write_reg(1'b0, 8'h00);
    bus.IRQ_TRIG = 8'h00;
    checks++; if (bus.DOUT !== 8'h05) begin errors++; $display("FAIL race_hw_wins: got %h want 05", bus.DOUT); end
  endtask

  task automatic test_level_vs_edge();
    do_reset();
    write_reg(1'b1, 8'h05);
    pulse_ime_set();
    bus.IRQ_TRIG = 8'h05;
    cycle();
    cycle();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL level_req: got %b want 1", bus.INT_REQ); end
    bus.INT_TAKE = 1;
    cycle();
    bus.INT_TAKE = 0;
    checks++; if (bus.IRQ_ACK !== 8'h01) begin errors++; $display("FAIL level_ack: got %h want 01", bus.IRQ_ACK); end
    checks++; if (bus.DOUT !== 8'h05) begin errors++; $display("FAIL level_reset_after_dispatch: got %h want 05", bus.DOUT); end
    write_reg(1'b0, 8'h00);
    checks++; if (bus.DOUT !== 8'h01) begin errors++; $display("FAIL edge_held_once: got %h want 01", bus.DOUT); end
    cycle();
    checks++; if (bus.DOUT !== 8'h01) begin errors++; $display("FAIL edge_held_still_once: got %h want 01", bus.DOUT); end
    bus.IRQ_TRIG = 8'h00;
  endtask

  task automatic test_reset_in_dispatch();
    do_reset();
    write_reg(1'b1, 8'h04);
    pulse_ime_set();
    write_reg(1'b0, 8'h04);
    cycle();
    bus.INT_TAKE = 1;
    cycle();
    bus.INT_TAKE = 0;
    checks++; if (bus.IRQ_ACK !== 8'h04) begin errors++; $display("FAIL rst_pre_ack: got %h want 04", bus.IRQ_ACK); end
    #1 nRESET = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.IRQ_ACK !== 8'h00) begin errors++; $display("FAIL rst_ack_kill: got %h want 00", bus.IRQ_ACK); end
    checks++; if (bus.VECTOR !== 16'h0040) begin errors++; $display("FAIL rst_vector: got %h want 0040", bus.VECTOR); end
    checks++; if (bus.DOUT !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", bus.DOUT); end
    checks++; if (bus.WAKE !== 1'b0) begin errors++; $display("FAIL rst_wake: got %b want 0", bus.WAKE); end
    cycle();
    nRESET = 1'b1;
    cycle();
    checks++; if (bus.IRQ_ACK !== 8'h00) begin errors++; $display("FAIL rst_release_ack: got %h want 00", bus.IRQ_ACK); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.IRQ_TRIG = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.REG_WR   = ($urandom_range(0, 7) == 0);
      bus.REG_SEL  = 1'($urandom);
      bus.DIN      = 8'($urandom);
      bus.IME_SET  = ($urandom_range(0, 3) == 0);
      bus.IME_CLR  = ($urandom_range(0, 11) == 0);
      bus.INT_TAKE = 1'($urandom);
      cycle();
      checks++; if (bus.INT_REQ !== (m_phase == 1)) begin errors++; $display("FAIL rand_int_req @%0d: got %b want %b", n, bus.INT_REQ, (m_phase == 1)); end
      checks++; if (bus.IRQ_ACK !== ((m_phase == 2) ? m_ack : 8'h00)) begin errors++; $display("FAIL rand_ack @%0d: got %h want %h", n, bus.IRQ_ACK, (m_phase == 2) ? m_ack : 8'h00); end
      checks++; if (bus.VECTOR !== m_vec) begin errors++; $display("FAIL rand_vector @%0d: got %h want %h", n, bus.VECTOR, m_vec); end
      checks++; if (bus.WAKE !== |(m_if & m_ie)) begin errors++; $display("FAIL rand_wake @%0d: got %b want %b", n, bus.WAKE, |(m_if & m_ie)); end
      checks++; if (bus.DOUT !== m_dout) begin errors++; $display("FAIL rand_dout @%0d: got %h want %h", n, bus.DOUT, m_dout); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_dispatch();
    test_priority();
    test_cancel();
    test_wake_and_write_race();
    test_level_vs_edge();
    test_reset_in_dispatch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
